calc_inverse_search: RTL and testbench

//  Sequential inverse of the specialized-multiplier mapping f(n): 0..2 -> n; 3..5 -> 2n+1; 6..8 -> 2n-1; else 0.

---
 rtl/calc_pkg.sv | 15 +
 rtl/calc_inverse_search_if.sv | 34 +++
 rtl/calc_forward.sv | 32 +++
 rtl/calc_inverse_search.sv | 102 ++++++++++
 tb/tb_calc_inverse_search.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared types and band boundaries for the f(n) calculator family.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Last n of each band of f: identity, 2n+1, 2n-1.
  localparam int unsigned LO_END  = 2;
  localparam int unsigned MID_END = 5;
  localparam int unsigned HI_END  = 8;

endpackage

// File: rtl/calc_inverse_search_if.sv
// Request/result bundle for the inverse search.
interface calc_inverse_search_if #(
  parameter int unsigned W = 4
) ();

  logic         start;
  logic [W-1:0] target;
  logic         busy;
  logic         done;
  logic [1:0]   match_cnt;
  logic [W-1:0] pre_lo;
  logic [W-1:0] pre_hi;

  modport master (
    output start,
    output target,
    input  busy,
    input  done,
    input  match_cnt,
    input  pre_lo,
    input  pre_hi
  );

  modport slave (
    input  start,
    input  target,
    output busy,
    output done,
    output match_cnt,
    output pre_lo,
    output pre_hi
  );

endinterface

// File: rtl/calc_forward.sv
// Combinational forward mapping f(n): 0..2 -> n; 3..5 -> 2n+1; 6..8 -> 2n-1; else 0.
module calc_forward
  import calc_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] n,
  output logic [W-1:0] f
);

  logic [31:0] n_ext;
  logic [W:0]  f_wide;
  logic        unused_f_msb;

  assign n_ext = 32'(n);

  // Evaluate at W+1 bits so 2n+1 cannot overflow before truncation.
  always_comb begin
    f_wide = '0;
    if (n_ext <= LO_END) begin
      f_wide = {1'b0, n};
    end else if (n_ext <= MID_END) begin
      f_wide = {n, 1'b1};
    end else if (n_ext <= HI_END) begin
      f_wide = {n, 1'b0} - (W + 1)'(1);
    end
  end

  assign f            = f_wide[W-1:0];
  assign unused_f_msb = f_wide[W];

endmodule

// File: rtl/calc_inverse_search.sv
// Sequential inverse of f: scans n = 0..MAX_IN and captures up to two preimages of target.
module calc_inverse_search
  import calc_pkg::*;
#(
  parameter int unsigned W      = 4,
  parameter int unsigned MAX_IN = 8
) (
  input logic                  clk,
  input logic                  rst,
  calc_inverse_search_if.slave bus
);

  localparam logic [W-1:0] CandLast = W'(MAX_IN);

  state_e       state_q, state_d;
  logic [W-1:0] cand_q, cand_d;
  logic [W-1:0] target_q, target_d;
  logic [1:0]   match_cnt_q, match_cnt_d;
  logic [W-1:0] pre_lo_q, pre_lo_d;
  logic [W-1:0] pre_hi_q, pre_hi_d;
  logic [W-1:0] f_cand;
  logic         hit;

  calc_forward #(
    .W (W)
  ) u_forward (
    .n (cand_q),
    .f (f_cand)
  );

  assign hit = (f_cand == target_q);

  // State and capture registers; reset clears everything, aborting any scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      target_q    <= '0;
      match_cnt_q <= '0;
      pre_lo_q    <= '0;
      pre_hi_q    <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      target_q    <= target_d;
      match_cnt_q <= match_cnt_d;
      pre_lo_q    <= pre_lo_d;
      pre_hi_q    <= pre_hi_d;
    end
  end

  // Next-state: accept start in IDLE/DONE, step the candidate and capture hits in SCAN.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    target_d    = target_q;
    match_cnt_d = match_cnt_q;
    pre_lo_d    = pre_lo_q;
    pre_hi_d    = pre_hi_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = SCAN;
          target_d    = bus.target;
          cand_d      = '0;
          match_cnt_d = '0;
          pre_lo_d    = '0;
          pre_hi_d    = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (hit) begin
          if (match_cnt_q == 2'd0) begin
            pre_lo_d = cand_q;
          end else if (match_cnt_q == 2'd1) begin
            pre_hi_d = cand_q;
          end
          if (match_cnt_q != 2'd3) begin
            match_cnt_d = match_cnt_q + 2'd1;
          end
        end
        // Candidate stops at the last value; the next accepted start rewinds it.
        if (cand_q == CandLast) begin
          state_d = DONE;
        end else begin
          cand_d = cand_q + W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.match_cnt = match_cnt_q;
  assign bus.pre_lo    = pre_lo_q;
  assign bus.pre_hi    = pre_hi_q;

endmodule

// File: tb/tb_calc_inverse_search.sv
// Directed bench for calc_inverse_search: latency, preimage capture, ignore/abort/re-arm cases.
module tb_calc_inverse_search;

  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  calc_inverse_search_if #(.W(W)) bus ();

  calc_inverse_search #(
    .W      (W),
    .MAX_IN (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge; returns at the negedge of cycle 1 after the accepting edge.
  task automatic pulse_start(input logic [W-1:0] t);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = t;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Walk negedges until done; lat is the cycle index since the accepting edge (-1 on timeout).
  task automatic wait_done(input int lat_in, output int lat, output int busy_n);
    lat    = lat_in;
    busy_n = 0;
    while (1) begin
      if (bus.busy) busy_n++;
      if (bus.done) break;
      if (lat > 40) begin
        lat = -1;
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.target = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.done, bus.match_cnt, bus.pre_lo, bus.pre_hi} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b cnt=%0d lo=%0d hi=%0d, want all 0",
               bus.busy, bus.done, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_two_preimages();
    int lat, busy_n;
    pulse_start(4'd11);
    wait_done(1, lat, busy_n);
    n_checks++;
    if (lat !== 10) begin
      n_fail++;
      $display("FAIL t11_latency: got %0d, want 10", lat);
    end
    n_checks++;
    if (busy_n !== 9) begin
      n_fail++;
      $display("FAIL t11_busy_cycles: got %0d, want 9", busy_n);
    end
    n_checks++;
    if ({bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd2, 4'd5, 4'd6}) begin
      n_fail++;
      $display("FAIL t11_result: got cnt=%0d lo=%0d hi=%0d, want 2/5/6",
               bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t11_done_pulse: got done=%b busy=%b one cycle later, want 0/0",
               bus.done, bus.busy);
    end
    n_checks++;
    if ({bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd2, 4'd5, 4'd6}) begin
      n_fail++;
      $display("FAIL t11_hold: got cnt=%0d lo=%0d hi=%0d, want 2/5/6",
               bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
  endtask

  task automatic test_edges();
    int lat, busy_n;
    pulse_start(4'd0);
    wait_done(1, lat, busy_n);
    n_checks++;
    if (lat !== 10 || {bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd1, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL t0_result: got lat=%0d cnt=%0d lo=%0d hi=%0d, want 10 1/0/0",
               lat, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    pulse_start(4'd15);
    wait_done(1, lat, busy_n);
    n_checks++;
    if (lat !== 10 || {bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd1, 4'd8, 4'd0}) begin
      n_fail++;
      $display("FAIL t15_result: got lat=%0d cnt=%0d lo=%0d hi=%0d, want 10 1/8/0",
               lat, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
  endtask

  task automatic test_unreachable();
    int lat, busy_n;
    pulse_start(4'd3);
    wait_done(1, lat, busy_n);
    n_checks++;
    if (lat !== 10 || {bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd0, 4'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL t3_result: got lat=%0d cnt=%0d lo=%0d hi=%0d, want 10 0/0/0",
               lat, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
  endtask

  task automatic test_start_ignored();
    int lat, busy_n;
    pulse_start(4'd9);
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 4'd13;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5, lat, busy_n);
    n_checks++;
    if (lat !== 10 || {bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd1, 4'd4, 4'd0}) begin
      n_fail++;
      $display("FAIL ignore_start: got lat=%0d cnt=%0d lo=%0d hi=%0d, want 10 1/4/0",
               lat, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int lat, busy_n;
    int done_seen;
    pulse_start(4'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.match_cnt, bus.pre_lo, bus.pre_hi} !== '0) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b done=%b cnt=%0d lo=%0d hi=%0d, want all 0",
               bus.busy, bus.done, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d busy/done cycles after abort, want 0", done_seen);
    end
    pulse_start(4'd7);
    wait_done(1, lat, busy_n);
    n_checks++;
    if (lat !== 10 || {bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd1, 4'd3, 4'd0}) begin
      n_fail++;
      $display("FAIL abort_restart: got lat=%0d cnt=%0d lo=%0d hi=%0d, want 10 1/3/0",
               lat, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    pulse_start(4'd1);
    repeat (8) @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 4'd1;
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b1 || {bus.match_cnt, bus.pre_lo} !== {2'd1, 4'd1}) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b cnt=%0d lo=%0d, want 1 1/1",
               bus.done, bus.match_cnt, bus.pre_lo);
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.match_cnt !== 2'd0) begin
      n_fail++;
      $display("FAIL b2b_rearm: got busy=%b cnt=%0d, want 1 0", bus.busy, bus.match_cnt);
    end
    wait_done(1, lat, busy_n);
    n_checks++;
    if (lat !== 10 || {bus.match_cnt, bus.pre_lo, bus.pre_hi} !== {2'd1, 4'd1, 4'd0}) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d cnt=%0d lo=%0d hi=%0d, want 10 1/1/0",
               lat, bus.match_cnt, bus.pre_lo, bus.pre_hi);
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_two_preimages();
    test_edges();
    test_unreachable();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
